// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and FSM state type for the MEM-stage data memory initiator.
package mem_access_pkg;

    localparam int LANE_W = 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WR
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-addressed data memory bus between the MEM stage and the Memory.
interface mem_access_unit_if;

    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic        MemWE;
    logic        MemRE;
    logic [31:0] MemRD;

    modport master (
        output MemA,
        output MemWD,
        output MemWE,
        output MemRE,
        input  MemRD
    );

    modport slave (
        input  MemA,
        input  MemWD,
        input  MemWE,
        input  MemRE,
        output MemRD
    );

endinterface

// File: rtl/mem_access_unit_lane_merge.sv
// Little-endian lane extract (loads) and lane insert (read-modify-write stores).
module lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] ext_o,
    output logic [31:0] ins_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh_b  = {addr_i, 3'b000};
        sh_h  = {addr_i[1], 4'b0000};
        b     = word_i[sh_b +: LANE_W];
        h     = word_i[sh_h +: 2*LANE_W];
        ext_o = word_i;
        ins_o = data_i;
        case (size_i)
            SIZE_BYTE: begin
                ext_o = {{24{signed_i & b[7]}}, b};
                ins_o = word_i;
                ins_o[sh_b +: LANE_W] = data_i[7:0];
            end
            SIZE_HALF: begin
                ext_o = {{16{signed_i & h[15]}}, h};
                ins_o = word_i;
                ins_o[sh_h +: 2*LANE_W] = data_i[15:0];
            end
            default: begin
                ext_o = word_i;
                ins_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word stores in one cycle, loads in two,
// sub-word stores as read-modify-write in three; bad requests flag ErrM.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] ADDR_BIAS = 32'h0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MemReadM,
    input  logic               MemWriteM,
    input  logic [1:0]         SizeM,
    input  logic               SignedM,
    input  logic [31:0]        ALUOutM,
    input  logic [31:0]        WriteDataM,
    output logic               StallM,
    output logic [31:0]        LoadDataM,
    output logic               LoadValidM,
    output logic               ErrM,
    mem_access_unit_if.master  mem
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        store_q, store_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] ldata_q, ldata_d;
    logic [31:0] ext;
    logic [31:0] ins;
    logic        req;
    logic        illegal;

    lane_merge u_lane (
        .word_i   (mem.MemRD),
        .data_i   (wdata_q),
        .addr_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (sign_q),
        .ext_o    (ext),
        .ins_o    (ins)
    );

    always_comb begin
        req     = MemReadM | MemWriteM;
        illegal = (MemReadM & MemWriteM)
                | (SizeM == SIZE_ILL)
                | ((SizeM == SIZE_HALF) & ALUOutM[0])
                | ((SizeM == SIZE_WORD) & (ALUOutM[1:0] != 2'b00));
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sign_d     = sign_q;
        store_d    = store_q;
        wdata_d    = wdata_q;
        merged_d   = merged_q;
        ldata_d    = ldata_q;
        StallM     = 1'b0;
        LoadValidM = 1'b0;
        ErrM       = 1'b0;
        LoadDataM  = ldata_q;
        mem.MemWE  = 1'b0;
        mem.MemRE  = 1'b0;
        mem.MemWD  = 32'h0;
        mem.MemA   = {addr_q[31:2], 2'b00} + ADDR_BIAS;
        unique case (state_q)
            IDLE: begin
                mem.MemA = {ALUOutM[31:2], 2'b00} + ADDR_BIAS;
                if (req && illegal) begin
                    ErrM = 1'b1;
                end else if (MemWriteM && SizeM == SIZE_WORD) begin
                    mem.MemWE = 1'b1;
                    mem.MemWD = WriteDataM;
                end else if (req) begin
                    mem.MemRE = 1'b1;
                    StallM    = 1'b1;
                    addr_d    = ALUOutM;
                    size_d    = SizeM;
                    sign_d    = SignedM;
                    store_d   = MemWriteM;
                    wdata_d   = WriteDataM;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (store_q) begin
                    merged_d = ins;
                    StallM   = 1'b1;
                    state_d  = RMW_WR;
                end else begin
                    LoadValidM = 1'b1;
                    LoadDataM  = ext;
                    ldata_d    = ext;
                    state_d    = IDLE;
                end
            end
            RMW_WR: begin
                mem.MemWE = 1'b1;
                mem.MemWD = merged_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset silences the bus at once so an in-flight RMW never writes.
        if (RST) begin
            StallM     = 1'b0;
            LoadValidM = 1'b0;
            ErrM       = 1'b0;
            LoadDataM  = ldata_q;
            mem.MemWE  = 1'b0;
            mem.MemRE  = 1'b0;
            mem.MemWD  = 32'h0;
            mem.MemA   = 32'h0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            size_q   <= SIZE_BYTE;
            sign_q   <= 1'b0;
            store_q  <= 1'b0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            ldata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            store_q  <= store_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            ldata_q  <= ldata_d;
        end
    end

endmodule
